// File: rtl/bullet_pkg.sv
// Shared types and helpers for the enemy-bullet pool: controller states,
// slot record and the per-frame position step / screen-bounds test.
package bullet_pkg;

  localparam int N_SLOTS_DEF = 8;
  localparam int SCR_W_DEF   = 640;
  localparam int SCR_H_DEF   = 480;
  localparam int COORD_W     = 10;
  localparam int VEL_W       = 4;
  localparam int POS_W       = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [VEL_W-1:0]   dx;
    logic [VEL_W-1:0]   dy;
  } slot_t;

  // Unsigned coordinate plus sign-extended velocity, in 11-bit signed space.
  function automatic logic signed [POS_W-1:0] step_pos(
    input logic [COORD_W-1:0] pos,
    input logic [VEL_W-1:0]   vel
  );
    return $signed({1'b0, pos}) + $signed({{(POS_W-VEL_W){vel[VEL_W-1]}}, vel});
  endfunction

  function automatic logic off_screen(
    input logic signed [POS_W-1:0] nx,
    input logic signed [POS_W-1:0] ny,
    input logic signed [POS_W-1:0] max_x,
    input logic signed [POS_W-1:0] max_y
  );
    return (nx < 11'sd0) || (nx > max_x) || (ny < 11'sd0) || (ny > max_y);
  endfunction

endpackage

// File: rtl/bullet_slot_alloc.sv
// Lowest-index free-slot finder over the pool's occupancy vector.
module bullet_slot_alloc
  import bullet_pkg::*;
#(
  parameter  int N_SLOTS = N_SLOTS_DEF,
  localparam int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic [N_SLOTS-1:0] i_valid,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  // First empty slot wins; later empty slots are ignored once one is found.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!i_valid[i] && !o_found) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end else begin
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Enemy-bullet slot pool: spawns into the lowest free slot, moves every
// occupied slot once per frame and frees bullets that leave the screen.
module bullet_pool_ctrl
  import bullet_pkg::*;
#(
  parameter  int N_SLOTS = N_SLOTS_DEF,
  parameter  int SCR_W   = SCR_W_DEF,
  parameter  int SCR_H   = SCR_H_DEF,
  localparam int IDX_W   = $clog2(N_SLOTS),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic               i_game_en,
  input  logic               i_clear_all,
  input  logic               i_spawn_req,
  input  logic [COORD_W-1:0] i_spawn_x,
  input  logic [COORD_W-1:0] i_spawn_y,
  input  logic [VEL_W-1:0]   i_spawn_dx,
  input  logic [VEL_W-1:0]   i_spawn_dy,
  output logic               o_spawn_ack,
  output logic               o_spawn_drop,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [COORD_W-1:0] o_rd_x,
  output logic [COORD_W-1:0] o_rd_y,
  output logic               o_rd_valid,
  output logic [CNT_W-1:0]   o_active_cnt,
  output logic               o_busy
);

  localparam logic signed [POS_W-1:0] MAX_X    = POS_W'(SCR_W - 1);
  localparam logic signed [POS_W-1:0] MAX_Y    = POS_W'(SCR_H - 1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_SLOTS - 1);

  slot_t             r_slots [N_SLOTS];
  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_ack;
  logic              r_drop;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;

  logic [N_SLOTS-1:0]      w_valid_vec;
  logic                    w_found;
  logic [IDX_W-1:0]        w_free_idx;
  slot_t                   w_cur;
  slot_t                   w_rd;
  logic signed [POS_W-1:0] w_nx;
  logic signed [POS_W-1:0] w_ny;
  logic                    w_off;

  // Occupancy vector feeding the allocator.
  always_comb begin
    w_valid_vec = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_valid_vec[i] = r_slots[i].valid;
    end
  end

  bullet_slot_alloc #(.N_SLOTS(N_SLOTS)) u_alloc (
    .i_valid (w_valid_vec),
    .o_found (w_found),
    .o_idx   (w_free_idx)
  );

  // Next position of the slot currently being swept.
  always_comb begin
    w_cur = r_slots[r_idx];
    w_nx  = step_pos(w_cur.x, w_cur.dx);
    w_ny  = step_pos(w_cur.y, w_cur.dy);
    w_off = off_screen(w_nx, w_ny, MAX_X, MAX_Y);
  end

  // Controller FSM; reset and bomb both flush the pool and abort any operation.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear_all) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ack   <= 1'b0;
      r_drop  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      r_ack  <= 1'b0;
      r_drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_frame_tick && i_game_en) begin
            r_state <= ST_UPDATE;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end else if (i_spawn_req && !r_ack && !r_drop) begin
            // A request answered this cycle is still high; don't take it twice.
            r_state <= ST_SPAWN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          if (w_cur.valid && w_off) begin
            r_slots[r_idx] <= '0;
            r_cnt          <= r_cnt - CNT_W'(1);
          end else if (w_cur.valid) begin
            r_slots[r_idx].x <= w_nx[COORD_W-1:0];
            r_slots[r_idx].y <= w_ny[COORD_W-1:0];
          end else begin
            r_cnt <= r_cnt;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_SPAWN: begin
          if (i_game_en && w_found) begin
            r_slots[w_free_idx] <= '{valid: 1'b1, x: i_spawn_x, y: i_spawn_y,
                                     dx: i_spawn_dx, dy: i_spawn_dy};
            r_cnt <= r_cnt + CNT_W'(1);
            r_ack <= 1'b1;
          end else begin
            r_drop <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign w_rd         = r_slots[i_rd_idx];
  assign o_rd_valid   = w_rd.valid;
  assign o_rd_x       = w_rd.valid ? w_rd.x : '0;
  assign o_rd_y       = w_rd.valid ? w_rd.y : '0;
  assign o_spawn_ack  = r_ack;
  assign o_spawn_drop = r_drop;
  assign o_busy       = r_busy;
  assign o_active_cnt = r_cnt;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Scoreboard bench for bullet_pool_ctrl: directed scenarios plus random
// spawn/frame/clear traffic checked against an array-based pool model.
module tb_bullet_pool_ctrl;

  localparam int N = 8;
  localparam int W = 640;
  localparam int H = 480;

  logic       clk = 1'b0;
  logic       reset, frame_tick, game_en, clear_all, spawn_req;
  logic [9:0] sx, sy;
  logic [3:0] sdx, sdy;
  logic       ack, drop;
  logic [2:0] rd_idx;
  logic [9:0] rd_x, rd_y;
  logic       rd_valid;
  logic [3:0] cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit m_valid [N];
  int m_x [N];
  int m_y [N];
  int m_dx [N];
  int m_dy [N];
  bit exp_q [$];
  bit prev_resp;
  bit mon_e;

  always #5 clk = ~clk;

  bullet_pool_ctrl #(.N_SLOTS(N), .SCR_W(W), .SCR_H(H)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_frame_tick (frame_tick),
    .i_game_en    (game_en),
    .i_clear_all  (clear_all),
    .i_spawn_req  (spawn_req),
    .i_spawn_x    (sx),
    .i_spawn_y    (sy),
    .i_spawn_dx   (sdx),
    .i_spawn_dy   (sdy),
    .o_spawn_ack  (ack),
    .o_spawn_drop (drop),
    .i_rd_idx     (rd_idx),
    .o_rd_x       (rd_x),
    .o_rd_y       (rd_y),
    .o_rd_valid   (rd_valid),
    .o_active_cnt (cnt),
    .o_busy       (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_valid[i] ? 1 : 0;
    return c;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0;
    end
  endfunction

  function automatic void model_frame();
    int nx, ny;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        nx = m_x[i] + m_dx[i];
        ny = m_y[i] + m_dy[i];
        if (nx < 0 || nx > W - 1 || ny < 0 || ny > H - 1) m_valid[i] = 1'b0;
        else begin m_x[i] = nx; m_y[i] = ny; end
      end
    end
  endfunction

  // Returns 1 when the model accepts the request (ack), 0 for a drop.
  function automatic bit model_spawn(input int x, input int y, input int dx, input int dy);
    if (!game_en) return 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!m_valid[i]) begin
        m_valid[i] = 1'b1; m_x[i] = x; m_y[i] = y; m_dx[i] = dx; m_dy[i] = dy;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_idx = 3'(i);
      #1;
      chk($sformatf("%s rd_valid[%0d]", tag, i), rd_valid, m_valid[i]);
      chk($sformatf("%s rd_x[%0d]", tag, i), rd_x, m_valid[i] ? m_x[i] : 0);
      chk($sformatf("%s rd_y[%0d]", tag, i), rd_y, m_valid[i] ? m_y[i] : 0);
    end
    chk($sformatf("%s active_cnt", tag), cnt, m_count());
  endtask

  task automatic do_spawn(input int x, input int y, input int dx, input int dy, input bit with_tick);
    int bcnt;
    int lat;
    bit got;
    bcnt = 0; lat = -1; got = 1'b0;
    if (with_tick && game_en) model_frame();
    exp_q.push_back(model_spawn(x, y, dx, dy));
    @(posedge clk); #1;
    sx = 10'(x); sy = 10'(y); sdx = 4'(dx); sdy = 4'(dy);
    spawn_req = 1'b1;
    frame_tick = with_tick;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      if (ack || drop) begin got = 1'b1; lat = c; end
      else if (busy) bcnt++;
    end
    spawn_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL spawn_timeout: got no ack/drop within 60 cycles, required one");
    end
    if (with_tick) chk("busy_before_spawn", bcnt, game_en ? N : 0);
    else chk("spawn_latency", lat, 1);
  endtask

  task automatic do_frame();
    int bcnt;
    bcnt = 0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    if (game_en) model_frame();
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("busy_cycles", bcnt, game_en ? N : 0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear_all = 1'b1;
    @(posedge clk); #1 clear_all = 1'b0;
    model_clear();
    chk("busy_after_clear", busy, 0);
  endtask

  // Monitor: pops the expected response whenever the DUT answers a spawn.
  always @(negedge clk) begin
    if (reset) prev_resp = 1'b0;
    else begin
      if (ack || drop) begin
        chk("resp_exclusive", ack & drop, 0);
        chk("resp_not_consecutive", prev_resp, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got ack=%0d drop=%0d, required none", ack, drop);
        end else begin
          mon_e = exp_q.pop_front();
          chk("spawn_resp_ack", ack, mon_e);
        end
      end
      prev_resp = ack || drop;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500000 ns, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; game_en = 1'b0; clear_all = 1'b0; spawn_req = 1'b0;
    sx = '0; sy = '0; sdx = '0; sdy = '0; rd_idx = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset ack", ack, 0);
    chk("reset drop", drop, 0);
    reset = 1'b0;
    check_all("reset");

    // Single spawn then one frame of motion.
    game_en = 1'b1;
    do_spawn(100, 100, 3, -2, 1'b0);
    check_all("spawn1");
    do_frame();
    check_all("move1");

    // Nine back-to-back requests into an 8-slot pool.
    do_clear();
    for (int i = 0; i < 9; i++) do_spawn(20 * i + 5, 30 + i, 1, 1, 1'b0);
    check_all("fill");

    // Edge exits on both sides, one survivor.
    do_clear();
    do_spawn(638, 10, 3, 0, 1'b0);
    do_spawn(0, 5, -1, 0, 1'b0);
    do_spawn(300, 200, 1, 1, 1'b0);
    do_spawn(10, 479, 0, 1, 1'b0);
    check_all("edge_pre");
    do_frame();
    check_all("edge_post");

    // Spawn request coincident with frame_tick: stored after the update, unmoved.
    do_spawn(50, 60, 2, 2, 1'b1);
    check_all("tick_spawn");

    // Bomb in the 4th update cycle.
    do_clear();
    for (int i = 0; i < 5; i++) do_spawn(100 + i, 200 + i, -3, 4, 1'b0);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_mid_update", busy, 1);
    clear_all = 1'b1;
    @(posedge clk); #1 clear_all = 1'b0;
    model_clear();
    chk("busy_after_bomb", busy, 0);
    check_all("bomb");

    // Gameplay paused: no motion, spawns dropped.
    do_spawn(400, 300, 5, -5, 1'b0);
    game_en = 1'b0;
    do_frame();
    check_all("paused_frame");
    do_spawn(10, 10, 1, 1, 1'b0);
    check_all("paused_spawn");
    game_en = 1'b1;

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        do_spawn(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, r == 0);
      end else if (r <= 8) begin
        do_frame();
      end else if ($urandom_range(0, 1) == 1) begin
        do_clear();
      end else begin
        @(posedge clk); #1 game_en = ~game_en;
      end
      check_all($sformatf("rand%0d", it));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
